// File: rtl/tank_pkg.sv
// ============================================================================
// Module   : tank_pkg
// Brief    : Shared tank/shell types for the scheduler and its slots.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tank_pkg;

    localparam int NUM_TANKS = 2;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1
    } dir_t;

    // dir is kept as raw bits so any value a tank controller drives passes through unchanged
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
        logic [9:0] elev;
        logic       owner;
    } shell_launch_t;

endpackage

`default_nettype wire

// File: rtl/shell_slot.sv
// ============================================================================
// Module   : shell_slot
// Brief    : One shell slot: occupancy, owning tank and remaining lifetime.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shell_slot #(
    parameter int SHELL_LIFE = 120
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic clear,
    input  logic alloc,
    input  logic alloc_owner,
    input  logic hit,
    output logic active,
    output logic owner
);

    localparam int LIFE_W = $clog2(SHELL_LIFE + 1);

    logic [LIFE_W-1:0] life;

    // alloc is only ever aimed at a slot that is free in registered state
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            active <= 1'b0;
            owner  <= 1'b0;
            life   <= '0;
        end else if (clear) begin
            active <= 1'b0;
            owner  <= 1'b0;
            life   <= '0;
        end else if (alloc) begin
            active <= 1'b1;
            owner  <= alloc_owner;
            life   <= LIFE_W'(SHELL_LIFE);
        end else if (active) begin
            if (hit || (life == LIFE_W'(1))) begin
                active <= 1'b0;
                life   <= '0;
            end else begin
                life <= life - LIFE_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/shell_scheduler.sv
// ============================================================================
// Module   : shell_scheduler
// Brief    : Shares the shell slot pool between two tanks with cooldown,
//            per-tank cap and round-robin arbitration; emits launch pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shell_scheduler
    import tank_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int RELOAD_FRAMES = 30,
    parameter int SHELL_LIFE    = 120
) (
    input  logic                         frame_clk,
    input  logic                         Reset,
    input  logic                         clear,
    input  logic [NUM_TANKS-1:0]         shoot_req,
    input  logic [19:0]                  tank_x,
    input  logic [19:0]                  tank_y,
    input  logic [3:0]                   tank_dir,
    input  logic [19:0]                  tank_elev,
    input  logic [NUM_SLOTS-1:0]         hit,
    output logic [NUM_TANKS-1:0]         ready,
    output logic [NUM_SLOTS-1:0]         slot_active,
    output logic [NUM_SLOTS-1:0]         slot_owner,
    output logic                         launch_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] launch_slot,
    output logic                         launch_owner,
    output logic [9:0]                   launch_x,
    output logic [9:0]                   launch_y,
    output logic [1:0]                   launch_dir,
    output logic [9:0]                   launch_elev
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int OWN_W  = $clog2(NUM_SLOTS / 2 + 1);
    localparam int CD_W   = $clog2(RELOAD_FRAMES + 1);
    localparam logic [OWN_W-1:0] CAP = OWN_W'(NUM_SLOTS / 2);

    logic [NUM_TANKS-1:0] req_prev;
    logic [NUM_TANKS-1:0] pending;
    logic [NUM_TANKS-1:0] req_rise;
    logic [NUM_TANKS-1:0] accept;
    logic [NUM_TANKS-1:0] want;
    logic [NUM_TANKS-1:0] grant_oh;
    logic [CD_W-1:0]      cooldown [NUM_TANKS];
    logic [OWN_W-1:0]     owned    [NUM_TANKS];
    logic                 rr_ptr;
    logic                 winner;
    logic                 grant_valid;
    logic                 any_free;
    logic [SLOT_W-1:0]    free_idx;
    logic [NUM_SLOTS-1:0] alloc;
    shell_launch_t        launch_next;
    shell_launch_t        launch_reg;

    // Ownership and readiness are derived only from registered state
    always_comb begin
        ready = '0;
        for (int t = 0; t < NUM_TANKS; t++) begin
            owned[t] = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_active[i] && (slot_owner[i] == 1'(t)))
                    owned[t] = owned[t] + OWN_W'(1);
            end
            ready[t] = (cooldown[t] == '0) && (owned[t] < CAP) && !pending[t];
        end
    end

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                any_free = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        req_rise    = shoot_req & ~req_prev;
        accept      = req_rise & ready;
        want        = pending | accept;
        winner      = (want == 2'b11) ? rr_ptr : want[1];
        grant_valid = any_free && (want != '0);
        grant_oh    = grant_valid ? (winner ? 2'b10 : 2'b01) : 2'b00;
        alloc       = grant_valid ? (NUM_SLOTS'(1) << free_idx) : '0;

        launch_next.x     = winner ? tank_x[19:10]   : tank_x[9:0];
        launch_next.y     = winner ? tank_y[19:10]   : tank_y[9:0];
        launch_next.dir   = winner ? tank_dir[3:2]   : tank_dir[1:0];
        launch_next.elev  = winner ? tank_elev[19:10] : tank_elev[9:0];
        launch_next.owner = winner;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            req_prev     <= '0;
            pending      <= '0;
            rr_ptr       <= 1'b0;
            launch_valid <= 1'b0;
            launch_slot  <= '0;
            launch_reg   <= '0;
            for (int t = 0; t < NUM_TANKS; t++) cooldown[t] <= '0;
        end else if (clear) begin
            req_prev     <= shoot_req;
            pending      <= '0;
            rr_ptr       <= 1'b0;
            launch_valid <= 1'b0;
            for (int t = 0; t < NUM_TANKS; t++) cooldown[t] <= '0;
        end else begin
            req_prev     <= shoot_req;
            pending      <= want & ~grant_oh;
            launch_valid <= grant_valid;
            if (grant_valid && (want == 2'b11))
                rr_ptr <= ~rr_ptr;
            for (int t = 0; t < NUM_TANKS; t++) begin
                if (grant_oh[t])
                    cooldown[t] <= CD_W'(RELOAD_FRAMES);
                else if (cooldown[t] != '0)
                    cooldown[t] <= cooldown[t] - CD_W'(1);
            end
            if (grant_valid) begin
                launch_slot <= free_idx;
                launch_reg  <= launch_next;
            end
        end
    end

    assign launch_owner = launch_reg.owner;
    assign launch_x     = launch_reg.x;
    assign launch_y     = launch_reg.y;
    assign launch_dir   = launch_reg.dir;
    assign launch_elev  = launch_reg.elev;

    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
            shell_slot #(
                .SHELL_LIFE (SHELL_LIFE)
            ) u_slot (
                .frame_clk   (frame_clk),
                .Reset       (Reset),
                .clear       (clear),
                .alloc       (alloc[i]),
                .alloc_owner (winner),
                .hit         (hit[i]),
                .active      (slot_active[i]),
                .owner       (slot_owner[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_shell_scheduler.sv
// ============================================================================
// Module   : tb_shell_scheduler
// Brief    : Scoreboard bench for shell_scheduler launches and slot state.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_shell_scheduler;

    logic        frame_clk = 1'b0;
    logic        Reset     = 1'b1;
    logic        clear     = 1'b0;
    logic [1:0]  shoot_req = '0;
    logic [19:0] tank_x    = '0;
    logic [19:0] tank_y    = '0;
    logic [3:0]  tank_dir  = '0;
    logic [19:0] tank_elev = '0;
    logic [3:0]  hit       = '0;
    logic [1:0]  ready;
    logic [3:0]  slot_active;
    logic [3:0]  slot_owner;
    logic        launch_valid;
    logic [1:0]  launch_slot;
    logic        launch_owner;
    logic [9:0]  launch_x;
    logic [9:0]  launch_y;
    logic [1:0]  launch_dir;
    logic [9:0]  launch_elev;

    shell_scheduler #(
        .NUM_SLOTS     (4),
        .RELOAD_FRAMES (30),
        .SHELL_LIFE    (120)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .clear        (clear),
        .shoot_req    (shoot_req),
        .tank_x       (tank_x),
        .tank_y       (tank_y),
        .tank_dir     (tank_dir),
        .tank_elev    (tank_elev),
        .hit          (hit),
        .ready        (ready),
        .slot_active  (slot_active),
        .slot_owner   (slot_owner),
        .launch_valid (launch_valid),
        .launch_slot  (launch_slot),
        .launch_owner (launch_owner),
        .launch_x     (launch_x),
        .launch_y     (launch_y),
        .launch_dir   (launch_dir),
        .launch_elev  (launch_elev)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int         edge_f;
        logic [1:0] slot;
        logic       owner;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
        logic [9:0] elev;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frame    = 0;

    always @(posedge frame_clk) frame <= frame + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (frame %0d)", name, act, expv, frame);
        end
    endtask

    task automatic wait_until(input int f);
        while (frame < f) begin
            @(posedge frame_clk);
            #2;
        end
    endtask

    task automatic set_pos(input int s);
        tank_x    = {10'(s * 40 + 5),  10'(s * 30 + 1)};
        tank_y    = {10'(s * 11 + 7),  10'(s * 13 + 2)};
        tank_dir  = {2'(s + 1),        2'(s)};
        tank_elev = {10'(s * 17 + 9),  10'(s * 19 + 4)};
    endtask

    // Expected launch built from the tank inputs the bench is holding
    task automatic push_exp(input int f, input int slot, input int t);
        exp_t e;
        e.edge_f = f;
        e.slot   = 2'(slot);
        e.owner  = 1'(t);
        e.x      = (t != 0) ? tank_x[19:10]    : tank_x[9:0];
        e.y      = (t != 0) ? tank_y[19:10]    : tank_y[9:0];
        e.dir    = (t != 0) ? tank_dir[3:2]    : tank_dir[1:0];
        e.elev   = (t != 0) ? tank_elev[19:10] : tank_elev[9:0];
        exp_q.push_back(e);
    endtask

    always @(negedge frame_clk) begin
        if (!Reset && launch_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_launch: slot=%0d owner=%0d at frame %0d, no launch expected",
                         launch_slot, launch_owner, frame);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("launch_frame", 64'(frame), 64'(e.edge_f));
                check("launch_packet",
                      {launch_slot, launch_owner, launch_x, launch_y, launch_dir, launch_elev},
                      {e.slot, e.owner, e.x, e.y, e.dir, e.elev});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at frame %0d", frame);
        $fatal(1);
    end

    initial begin
        int g, e, r;

        repeat (3) @(posedge frame_clk);
        #2;
        check("reset_ready", ready, 2'b11);
        check("reset_launch_valid", launch_valid, 1'b0);
        check("reset_slot_active", slot_active, 4'b0000);
        check("reset_slot_owner", slot_owner, 4'b0000);
        Reset = 1'b0;

        // Single tank A shot into an idle pool, cooldown and full lifetime
        set_pos(1);
        g = frame + 1;
        shoot_req = 2'b01;
        push_exp(g, 0, 0);
        wait_until(g);
        check("a_ready_after_grant", ready[0], 1'b0);
        check("a_slot_active", slot_active, 4'b0001);
        shoot_req = 2'b00;
        wait_until(g + 29);
        check("a_cooldown_still_low", ready[0], 1'b0);
        wait_until(g + 30);
        check("a_cooldown_done", ready[0], 1'b1);
        wait_until(g + 119);
        check("life_119", slot_active, 4'b0001);
        wait_until(g + 120);
        check("life_120_freed", slot_active, 4'b0000);
        check("ready_idle", ready, 2'b11);

        // Contention: A wins first, then B wins after the pointer toggles
        set_pos(2);
        e = frame + 1;
        shoot_req = 2'b11;
        push_exp(e, 0, 0);
        push_exp(e + 1, 1, 1);
        wait_until(e);
        check("contend_ready", ready, 2'b00);
        wait_until(e + 1);
        check("contend_active", slot_active, 4'b0011);
        check("contend_owner", slot_owner, 4'b0010);
        shoot_req = 2'b00;
        wait_until(e + 31);
        check("contend_ready_again", ready, 2'b11);
        set_pos(3);
        shoot_req = 2'b11;
        push_exp(e + 32, 2, 1);
        push_exp(e + 33, 3, 0);
        wait_until(e + 33);
        check("pool_full", slot_active, 4'b1111);
        check("pool_full_owner", slot_owner, 4'b0110);
        shoot_req = 2'b00;

        // Per-tank cap drops A's third edge; a hit restores readiness
        wait_until(e + 64);
        check("cap_ready", ready, 2'b00);
        shoot_req = 2'b01;
        wait_until(e + 66);
        shoot_req = 2'b00;
        check("cap_no_launch", slot_active, 4'b1111);
        hit = 4'b0001;
        wait_until(e + 67);
        check("hit_frees_slot0", slot_active, 4'b1110);
        check("cap_released", ready[0], 1'b1);
        wait_until(e + 68);
        hit = 4'b0000;
        check("hit_free_slot_ignored", slot_active, 4'b1110);

        // Refill, then a freed slot is only grantable on the following edge
        set_pos(4);
        shoot_req = 2'b01;
        push_exp(e + 69, 0, 0);
        wait_until(e + 69);
        shoot_req = 2'b00;
        check("refill_full", slot_active, 4'b1111);
        wait_until(e + 120);
        check("before_expire", slot_active, 4'b1111);
        check("b_capped", ready[1], 1'b0);
        wait_until(e + 121);
        check("slot1_expired", slot_active, 4'b1101);
        check("b_ready_after_expire", ready, 2'b10);
        set_pos(5);
        shoot_req = 2'b10;
        push_exp(e + 122, 1, 1);
        wait_until(e + 122);
        shoot_req = 2'b00;
        check("slot1_regranted", slot_active, 4'b1111);

        // Grant in the same edge a lower slot is hit must use a registered-free slot
        wait_until(e + 153);
        check("two_expired", slot_active, 4'b0011);
        wait_until(e + 154);
        set_pos(6);
        hit = 4'b0010;
        shoot_req = 2'b01;
        push_exp(e + 155, 2, 0);
        wait_until(e + 155);
        hit = 4'b0000;
        shoot_req = 2'b00;
        check("same_edge_hit_grant", slot_active, 4'b0101);

        // Fresh shell hit ten frames after launch
        set_pos(7);
        shoot_req = 2'b10;
        push_exp(e + 156, 1, 1);
        wait_until(e + 156);
        shoot_req = 2'b00;
        check("b_into_slot1", slot_active, 4'b0111);
        wait_until(e + 165);
        check("slot1_alive", slot_active[1], 1'b1);
        hit = 4'b0010;
        wait_until(e + 166);
        hit = 4'b0000;
        check("slot1_hit_at_10", slot_active, 4'b0101);

        // Clear while a shell is live and the contention loser is pending
        wait_until(e + 190);
        check("pre_clear_active", slot_active, 4'b0100);
        check("pre_clear_ready", ready, 2'b11);
        set_pos(8);
        shoot_req = 2'b11;
        push_exp(e + 191, 0, 0);
        wait_until(e + 191);
        check("pending_b_active", slot_active, 4'b0101);
        check("pending_b_ready", ready, 2'b00);
        clear = 1'b1;
        wait_until(e + 192);
        clear = 1'b0;
        check("clear_active", slot_active, 4'b0000);
        check("clear_ready", ready, 2'b11);
        check("clear_launch", launch_valid, 1'b0);
        wait_until(e + 193);
        check("held_req_no_fire", slot_active, 4'b0000);
        shoot_req = 2'b00;

        // Asynchronous reset during a launch pulse
        wait_until(e + 195);
        set_pos(9);
        shoot_req = 2'b01;
        wait_until(e + 196);
        check("launch_before_reset", launch_valid, 1'b1);
        check("launch_slot_before_reset", launch_slot, 2'd0);
        #1 Reset = 1'b1;
        #1;
        check("async_reset_launch", launch_valid, 1'b0);
        check("async_reset_ready", ready, 2'b11);
        repeat (2) @(posedge frame_clk);
        #2;
        r = frame;
        Reset = 1'b0;
        push_exp(r + 1, 0, 0);
        wait_until(r + 1);
        check("held_through_reset_fires", slot_active, 4'b0001);
        shoot_req = 2'b00;
        wait_until(r + 3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
